// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared constants and FSM state type for the multiplexed AddrData memory bus
package mem_bus_pkg;
  localparam int BURST_LEN = 4;
  localparam int BEAT_W = 16;
  localparam logic [15:0] PAGE_MASK = 16'hF000;
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, TURN = 2'd3} mem_bus_state_t;
endpackage

// File: rtl/mem_bus_master_if.sv
// mem_bus_master_if: local burst request/response port of the bus master
interface mem_bus_master_if;
  import mem_bus_pkg::*;
  logic req_valid;
  logic req_ready;
  logic req_rw;
  logic [BEAT_W-1:0] req_addr;
  logic [BURST_LEN*BEAT_W-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_rw;
  logic [BURST_LEN*BEAT_W-1:0] rsp_rdata;
  logic busy;
  modport master (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rw, rsp_rdata, busy
  );
  modport slave (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rw, rsp_rdata, busy
  );
endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master: runs one 4-beat read/write burst per request on the AddrData bus
module mem_bus_master
  import mem_bus_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetH,
  mem_bus_master_if.master     host,
  inout  wire  [BEAT_W-1:0]    AddrData,
  output logic                 AddrValid,
  output logic                 rw
);
  localparam int W = BURST_LEN * BEAT_W;
  localparam int BW = $clog2(BURST_LEN);
  mem_bus_state_t state;
  logic [BW-1:0] beat;
  logic [W-1:0] wbuf, rbuf, rnext, rdata_q;
  logic [BEAT_W-1:0] ad_q;
  logic ad_oe, rsp_rw_q, last;
  assign last = beat == BW'(BURST_LEN - 1);
  assign rnext = {AddrData, rbuf[W-1:BEAT_W]};
  assign host.req_ready = state == IDLE;
  assign host.rsp_valid = state == TURN;
  assign host.busy = state != IDLE;
  assign host.rsp_rw = rsp_rw_q;
  assign host.rsp_rdata = rdata_q;
  assign AddrValid = state == ADDR;
  // drive enable and value are both flops so the bus only moves on clock edges
  assign AddrData = ad_oe ? ad_q : 'z;
  always_ff @(posedge clk or posedge resetH)
    if (resetH) begin
      state <= IDLE;
      beat <= '0;
      rw <= 1'b0;
      wbuf <= '0;
      rbuf <= '0;
      rdata_q <= '0;
      rsp_rw_q <= 1'b0;
      ad_oe <= 1'b0;
      ad_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (host.req_valid) begin
          state <= ADDR;
          rw <= host.req_rw;
          wbuf <= host.req_wdata;
          ad_oe <= 1'b1;
          ad_q <= host.req_addr;
        end
        ADDR: begin
          state <= DATA;
          beat <= '0;
          ad_oe <= !rw;
          ad_q <= wbuf[BEAT_W-1:0];
          wbuf <= wbuf >> BEAT_W;
        end
        DATA: begin
          beat <= beat + 1'b1;
          rbuf <= rnext;
          ad_q <= wbuf[BEAT_W-1:0];
          wbuf <= wbuf >> BEAT_W;
          if (last) begin
            state <= TURN;
            ad_oe <= 1'b0;
            rsp_rw_q <= rw;
            rdata_q <= rw ? rnext : rdata_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Bus initiator for the multiplexed 16-bit AddrData memory bus. It accepts one burst request at a time from a local valid/ready request port and runs a 4-beat read or write burst on AddrData/AddrValid/rw toward the paged memory controller. For reads it returns the 4 captured words as a single response. It sits on the CPU side of the bus and replaces testbench-driven bus stimulus.

## Interface
- BURST_LEN, 4: beats per burst; fixed protocol value, other values unsupported.
- clk  input  1  bus and logic clock.
- resetH  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  master can accept a request; high only in IDLE.
- req_rw  input  1  1 = read, 0 = write; sampled at acceptance.
- req_addr  input  16  burst start address; [15:12] selects the page, [7:0] is the word address; sampled at acceptance.
- req_wdata  input  64  write beats; beat 0 in [15:0], beat 3 in [63:48]; sampled at acceptance.
- rsp_valid  output  1  one-cycle pulse at burst completion, for reads and writes.
- rsp_rw  output  1  echo of the completed request's rw.
- rsp_rdata  output  64  read beats, same packing as req_wdata; holds its value until the next read completes.
- busy  output  1  high from acceptance until the cycle after rsp_valid.
- AddrData  inout  16  multiplexed address/data bus; tri-stated when not driving.
- AddrValid  output  1  high during the address cycle only.
- rw  output  1  bus direction; valid while AddrValid is high.

## Operation
- A request is accepted on the rising edge where req_valid && req_ready. All request fields are registered at that edge.
- FSM states: IDLE, ADDR, DATA, TURN.
- IDLE: req_ready=1, bus released. On acceptance, go to ADDR.
- ADDR (1 cycle): AddrValid=1, rw=registered rw, AddrData=registered address. Beat counter cleared to 0. Next state: DATA.
- DATA (BURST_LEN cycles, beat counter 0..3):
  - Write: AddrData driven with beat[counter].
  - Read: AddrData released (z). Bus value is captured into rsp_rdata beat[counter] at the rising edge ending that cycle. Z or X values are captured as-is, unchecked.
  - After counter==3, go to TURN.
- TURN (1 cycle): bus released, AddrValid=0, rsp_valid=1. Next state: IDLE.
- The address is not incremented by the master; the responder increments it.
- The AddrData drive enable and drive value come from flops, so AddrData is glitch-free and only changes on clock edges.
- A request that is held while busy sees req_ready=0 and must remain stable on the request port until accepted.

## Timing
- Reset values (async): state=IDLE, req_ready=1, AddrValid=0, rw=0, AddrData=z, rsp_valid=0, rsp_rw=0, rsp_rdata=0, busy=0, beat counter=0.
- Acceptance edge E0 → ADDR in cycle 1 → DATA beats 0..3 in cycles 2–5 → TURN/rsp_valid in cycle 6 → req_ready=1 in cycle 7.
- Back-to-back throughput: one burst per 7 cycles; rsp_valid never lasts 2 consecutive cycles.
- TURN guarantees at least one bus-idle cycle between the responder's last read drive and the next ADDR drive.
- Read sample point: the rising edge at the end of each DATA cycle.
- Reset mid-burst: AddrData releases and AddrValid drops immediately (asynchronously). No rsp_valid is generated and the in-flight request is discarded.
- req_valid asserted in the same cycle reset deasserts: the request is not accepted until the first edge with resetH low.

## Structure
- Shared package mem_bus_pkg holds:
  - state enum mem_bus_state_t (IDLE, ADDR, DATA, TURN);
  - BURST_LEN=4;
  - BEAT_W=16;
  - PAGE_MASK=16'hF000.
- The memory controller imports the same package for BURST_LEN and PAGE_MASK.
- Single module; no sub-module. The tri-state drive is an inline continuous assignment from the drive-enable and drive-data flops.

## Test plan
- Reset: hold resetH high 2 cycles → AddrData=z, AddrValid=0, req_ready=1, rsp_valid=0, rsp_rdata=0.
- Write burst: req_addr=16'h2010, req_rw=0, req_wdata=64'h4444_3333_2222_1111 → cycle 1 AddrData=16'h2010 with AddrValid=1 and rw=0; cycles 2–5 AddrData=1111, 2222, 3333, 4444; rsp_valid in cycle 6 with rsp_rw=0.
- Read burst: behavioral responder drives AABB, CCDD, EEFF, 0123 in DATA cycles for req_addr=16'h2010, req_rw=1 → master leaves AddrData at z in cycles 2–5; rsp_rdata=64'h0123_EEFF_CCDD_AABB with rsp_valid in cycle 6.
- Back-to-back: req_valid held high with a write then a read → second AddrValid exactly 7 cycles after the first; req_ready low for cycles 1–6; no bus contention (no X on AddrData).
- Reset in DATA beat 2 of a write → AddrData=z and AddrValid=0 in the same cycle; no rsp_valid afterwards; the next request runs normally.
- Integration: write 16'h2040 with 64'h0D0C_0B0A_0908_0706, then read 16'h2040 against the mem_controller with PAGE=2 → the words read back match the memory contents the controller returns. Repeating the write to page 3 (16'h3040) → memory is unchanged.
